// File: rtl/rv32i_pkg.sv
// Shared RV32I decode constants: base opcodes, ALU opcodes, funct3 codes,
// immediate-format selectors and small decode helpers.
package rv32i_pkg;

    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] BRANCH = 7'b1100011;

    localparam logic [3:0] ULA_ADD    = 4'd0;
    localparam logic [3:0] ULA_SUB    = 4'd1;
    localparam logic [3:0] ULA_XOR    = 4'd2;
    localparam logic [3:0] ULA_OR     = 4'd3;
    localparam logic [3:0] ULA_AND    = 4'd4;
    localparam logic [3:0] ULA_SLL    = 4'd5;
    localparam logic [3:0] ULA_SRL    = 4'd6;
    localparam logic [3:0] ULA_SRA    = 4'd7;
    localparam logic [3:0] ULA_SLT    = 4'd8;
    localparam logic [3:0] ULA_SLTU   = 4'd9;
    localparam logic [3:0] ULA_PASS_A = 4'd15;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_SLTU    = 3'b011;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SRL_SRA = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    localparam logic [2:0] IMM_I = 3'd0;
    localparam logic [2:0] IMM_S = 3'd1;
    localparam logic [2:0] IMM_B = 3'd2;
    localparam logic [2:0] IMM_U = 3'd3;
    localparam logic [2:0] IMM_J = 3'd4;

    // alt selects SUB/SRA; callers must only raise it where the encoding allows.
    function automatic logic [3:0] alu_op(input logic [2:0] f3, input logic alt);
        logic [3:0] op;
        op = ULA_ADD;
        case (f3)
            F3_ADD_SUB: op = alt ? ULA_SUB : ULA_ADD;
            F3_SLL:     op = ULA_SLL;
            F3_SLT:     op = ULA_SLT;
            F3_SLTU:    op = ULA_SLTU;
            F3_XOR:     op = ULA_XOR;
            F3_SRL_SRA: op = alt ? ULA_SRA : ULA_SRL;
            F3_OR:      op = ULA_OR;
            F3_AND:     op = ULA_AND;
            default:    op = ULA_ADD;
        endcase
        return op;
    endfunction

    function automatic logic load_f3_ok(input logic [2:0] f3);
        return (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
               (f3 == F3_LBU) || (f3 == F3_LHU);
    endfunction

    function automatic logic store_f3_ok(input logic [2:0] f3);
        return (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
    endfunction

endpackage

// File: rtl/imm_gen.sv
// Combinational RV32I immediate generator: builds the I/S/B/U/J immediates
// from the instruction word and returns the one chosen by fmt.
module imm_gen
    import rv32i_pkg::*;
(
    input  logic [31:7] instr,
    input  logic [2:0]  fmt,
    output logic [31:0] imm
);

    logic signed [31:0] imm_i;
    logic signed [31:0] imm_s;
    logic signed [31:0] imm_b;
    logic signed [31:0] imm_u;
    logic signed [31:0] imm_j;

    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u = {instr[31:12], 12'b0};
    assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    always_comb begin
        imm = imm_i;
        case (fmt)
            IMM_S:   imm = imm_s;
            IMM_B:   imm = imm_b;
            IMM_U:   imm = imm_u;
            IMM_J:   imm = imm_j;
            default: imm = imm_i;
        endcase
    end

endmodule

// File: rtl/id_ex_decoder.sv
// RV32I decode/issue stage with load-use bubble insertion and the ID/EX register.
// Define ID_EX_ILLEGAL_CHECK_EN to flag undecodable instructions on ex_illegal.
module id_ex_decoder
    import rv32i_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            id_valid,
    output logic            id_ready,
    input  logic [31:0]     id_instr,
    input  logic [XLEN-1:0] id_pc,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic            ex_stall,
    input  logic            ex_flush,
    output logic            ex_valid,
    output logic [3:0]      ex_ula_op,
    output logic [XLEN-1:0] ex_op_a,
    output logic [XLEN-1:0] ex_op_b,
    output logic [XLEN-1:0] ex_store_data,
    output logic [4:0]      ex_rd,
    output logic            ex_reg_write,
    output logic            ex_mem_read,
    output logic            ex_mem_write,
    output logic            ex_branch,
    output logic            ex_jump,
    output logic [2:0]      ex_funct3,
    output logic            ex_illegal
);

    logic [6:0] opcode;
    logic [4:0] rd_idx, rs1_idx, rs2_idx;
    logic [2:0] funct3;
    logic [2:0] imm_fmt;
    logic [31:0] imm;

    assign opcode  = id_instr[6:0];
    assign rd_idx  = id_instr[11:7];
    assign funct3  = id_instr[14:12];
    assign rs1_idx = id_instr[19:15];
    assign rs2_idx = id_instr[24:20];

    always_comb begin
        imm_fmt = IMM_I;
        case (opcode)
            STORE:       imm_fmt = IMM_S;
            BRANCH:      imm_fmt = IMM_B;
            LUI, AUIPC:  imm_fmt = IMM_U;
            JAL:         imm_fmt = IMM_J;
            default:     imm_fmt = IMM_I;
        endcase
    end

    imm_gen u_imm_gen (
        .instr (id_instr[31:7]),
        .fmt   (imm_fmt),
        .imm   (imm)
    );

    // ---- p0: combinational decode of the instruction at the decode input ----
    logic [3:0]      ula_op_p0;
    logic [XLEN-1:0] op_a_p0, op_b_p0;
    logic            reg_write_p0, mem_read_p0, mem_write_p0;
    logic            branch_p0, jump_p0, illegal_p0;
    logic            use_rs1, use_rs2;

    always_comb begin
        ula_op_p0    = ULA_ADD;
        op_a_p0      = rs1_data;
        op_b_p0      = rs2_data;
        reg_write_p0 = 1'b0;
        mem_read_p0  = 1'b0;
        mem_write_p0 = 1'b0;
        branch_p0    = 1'b0;
        jump_p0      = 1'b0;
        illegal_p0   = 1'b0;
        use_rs1      = 1'b0;
        use_rs2      = 1'b0;
        case (opcode)
            OP: begin
                use_rs1      = 1'b1;
                use_rs2      = 1'b1;
                reg_write_p0 = 1'b1;
                ula_op_p0    = alu_op(funct3, id_instr[30]);
                // The ALU shifts by the whole B operand, so clip to 5 bits here.
                if (funct3 == F3_SLL || funct3 == F3_SRL_SRA)
                    op_b_p0 = {{(XLEN-5){1'b0}}, rs2_data[4:0]};
`ifdef ID_EX_ILLEGAL_CHECK_EN
                if (id_instr[31:25] != 7'b0000000 && id_instr[31:25] != 7'b0100000)
                    illegal_p0 = 1'b1;
`endif
            end
            OP_IMM: begin
                use_rs1      = 1'b1;
                reg_write_p0 = 1'b1;
                ula_op_p0    = alu_op(funct3, (funct3 == F3_SRL_SRA) && id_instr[30]);
                if (funct3 == F3_SLL || funct3 == F3_SRL_SRA)
                    op_b_p0 = {{(XLEN-5){1'b0}}, id_instr[24:20]};
                else
                    op_b_p0 = imm;
            end
            LUI: begin
                reg_write_p0 = 1'b1;
                op_a_p0      = '0;
                op_b_p0      = imm;
            end
            AUIPC: begin
                reg_write_p0 = 1'b1;
                op_a_p0      = id_pc;
                op_b_p0      = imm;
            end
            JAL, JALR: begin
                use_rs1      = (opcode == JALR);
                reg_write_p0 = 1'b1;
                jump_p0      = 1'b1;
                op_a_p0      = id_pc;
                op_b_p0      = XLEN'(4);
            end
            LOAD: begin
                use_rs1      = 1'b1;
                reg_write_p0 = 1'b1;
                mem_read_p0  = 1'b1;
                op_b_p0      = imm;
`ifdef ID_EX_ILLEGAL_CHECK_EN
                illegal_p0   = !load_f3_ok(funct3);
`endif
            end
            STORE: begin
                use_rs1      = 1'b1;
                use_rs2      = 1'b1;
                mem_write_p0 = 1'b1;
                op_b_p0      = imm;
`ifdef ID_EX_ILLEGAL_CHECK_EN
                illegal_p0   = !store_f3_ok(funct3);
`endif
            end
            BRANCH: begin
                use_rs1   = 1'b1;
                use_rs2   = 1'b1;
                branch_p0 = 1'b1;
                case (funct3)
                    F3_BEQ, F3_BNE:   ula_op_p0 = ULA_SUB;
                    F3_BLT, F3_BGE:   ula_op_p0 = ULA_SLT;
                    F3_BLTU, F3_BGEU: ula_op_p0 = ULA_SLTU;
                    default: begin
                        ula_op_p0 = ULA_SUB;
`ifdef ID_EX_ILLEGAL_CHECK_EN
                        illegal_p0 = 1'b1;
`endif
                    end
                endcase
            end
            default: begin
`ifdef ID_EX_ILLEGAL_CHECK_EN
                illegal_p0 = 1'b1;
`endif
            end
        endcase
        if (illegal_p0) begin
            ula_op_p0    = ULA_PASS_A;
            reg_write_p0 = 1'b0;
            mem_read_p0  = 1'b0;
            mem_write_p0 = 1'b0;
            branch_p0    = 1'b0;
            jump_p0      = 1'b0;
        end
        if (rd_idx == 5'd0)
            reg_write_p0 = 1'b0;
    end

    logic            vld_p1;
    logic [3:0]      ula_op_p1;
    logic [XLEN-1:0] op_a_p1, op_b_p1, store_data_p1;
    logic [4:0]      rd_p1;
    logic            reg_write_p1, mem_read_p1, mem_write_p1;
    logic            branch_p1, jump_p1, illegal_p1;
    logic [2:0]      funct3_p1;
    logic            hazard;

    assign hazard = id_valid && vld_p1 && mem_read_p1 && (rd_p1 != 5'd0) &&
                    ((use_rs1 && rs1_idx == rd_p1) || (use_rs2 && rs2_idx == rd_p1));

    assign id_ready = ex_flush || (!ex_stall && !hazard);

    // ---- p1: ID/EX pipeline register ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1        <= 1'b0;
            ula_op_p1     <= '0;
            op_a_p1       <= '0;
            op_b_p1       <= '0;
            store_data_p1 <= '0;
            rd_p1         <= '0;
            reg_write_p1  <= 1'b0;
            mem_read_p1   <= 1'b0;
            mem_write_p1  <= 1'b0;
            branch_p1     <= 1'b0;
            jump_p1       <= 1'b0;
            funct3_p1     <= '0;
            illegal_p1    <= 1'b0;
        end else if (ex_flush || (!ex_stall && (!id_valid || hazard))) begin
            vld_p1       <= 1'b0;
            reg_write_p1 <= 1'b0;
            mem_read_p1  <= 1'b0;
            mem_write_p1 <= 1'b0;
            branch_p1    <= 1'b0;
            jump_p1      <= 1'b0;
            illegal_p1   <= 1'b0;
        end else if (!ex_stall) begin
            vld_p1        <= 1'b1;
            ula_op_p1     <= ula_op_p0;
            op_a_p1       <= op_a_p0;
            op_b_p1       <= op_b_p0;
            store_data_p1 <= rs2_data;
            rd_p1         <= rd_idx;
            reg_write_p1  <= reg_write_p0;
            mem_read_p1   <= mem_read_p0;
            mem_write_p1  <= mem_write_p0;
            branch_p1     <= branch_p0;
            jump_p1       <= jump_p0;
            funct3_p1     <= funct3;
            illegal_p1    <= illegal_p0;
        end
    end

    assign ex_valid      = vld_p1;
    assign ex_ula_op     = ula_op_p1;
    assign ex_op_a       = op_a_p1;
    assign ex_op_b       = op_b_p1;
    assign ex_store_data = store_data_p1;
    assign ex_rd         = rd_p1;
    assign ex_reg_write  = reg_write_p1;
    assign ex_mem_read   = mem_read_p1;
    assign ex_mem_write  = mem_write_p1;
    assign ex_branch     = branch_p1;
    assign ex_jump       = jump_p1;
    assign ex_funct3     = funct3_p1;
    assign ex_illegal    = illegal_p1;

endmodule

// File: tb/tb_id_ex_decoder.sv
// Directed bench for id_ex_decoder: hand-assembled RV32I instructions with
// hand-computed ALU opcodes, operands, control bits and stall/hazard timing.
module tb_id_ex_decoder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        id_valid = 1'b0;
    logic        id_ready;
    logic [31:0] id_instr = '0;
    logic [31:0] id_pc = '0;
    logic [31:0] rs1_data = '0;
    logic [31:0] rs2_data = '0;
    logic        ex_stall = 1'b0;
    logic        ex_flush = 1'b0;
    logic        ex_valid;
    logic [3:0]  ex_ula_op;
    logic [31:0] ex_op_a, ex_op_b, ex_store_data;
    logic [4:0]  ex_rd;
    logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_jump;
    logic [2:0]  ex_funct3;
    logic        ex_illegal;

    int n_checks = 0;
    int n_errors = 0;

    id_ex_decoder #(.XLEN(32)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .id_valid      (id_valid),
        .id_ready      (id_ready),
        .id_instr      (id_instr),
        .id_pc         (id_pc),
        .rs1_data      (rs1_data),
        .rs2_data      (rs2_data),
        .ex_stall      (ex_stall),
        .ex_flush      (ex_flush),
        .ex_valid      (ex_valid),
        .ex_ula_op     (ex_ula_op),
        .ex_op_a       (ex_op_a),
        .ex_op_b       (ex_op_b),
        .ex_store_data (ex_store_data),
        .ex_rd         (ex_rd),
        .ex_reg_write  (ex_reg_write),
        .ex_mem_read   (ex_mem_read),
        .ex_mem_write  (ex_mem_write),
        .ex_branch     (ex_branch),
        .ex_jump       (ex_jump),
        .ex_funct3     (ex_funct3),
        .ex_illegal    (ex_illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] r_type(input logic [6:0] f7, input logic [4:0] rs2,
                                           input logic [4:0] rs1, input logic [2:0] f3,
                                           input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] i_type(input logic [11:0] imm, input logic [4:0] rs1,
                                           input logic [2:0] f3, input logic [4:0] rd,
                                           input logic [6:0] opc);
        return {imm, rs1, f3, rd, opc};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] instr, input logic [31:0] pc,
                         input logic [31:0] a, input logic [31:0] b);
        id_valid = 1'b1;
        id_instr = instr;
        id_pc    = pc;
        rs1_data = a;
        rs2_data = b;
    endtask

    initial begin
        #1 rst_n = 1'b0;
        step();
        step();
        chk("rst_valid", 32'(ex_valid), 32'd0);
        chk("rst_ula_op", 32'(ex_ula_op), 32'd0);
        chk("rst_op_a", ex_op_a, 32'd0);
        chk("rst_op_b", ex_op_b, 32'd0);
        chk("rst_rd", 32'(ex_rd), 32'd0);
        #2 rst_n = 1'b1;
        step();

        // ADD x3,x1,x2
        drive(r_type(7'h00, 5'd2, 5'd1, 3'b000, 5'd3), 32'h40, 32'd5, 32'd7);
        #1 chk("add_ready", 32'(id_ready), 32'd1);
        step();
        chk("add_valid", 32'(ex_valid), 32'd1);
        chk("add_ula_op", 32'(ex_ula_op), 32'd0);
        chk("add_op_a", ex_op_a, 32'd5);
        chk("add_op_b", ex_op_b, 32'd7);
        chk("add_rd", 32'(ex_rd), 32'd3);
        chk("add_reg_write", 32'(ex_reg_write), 32'd1);

        // SRAI x4,x1,31
        drive(i_type(12'h41F, 5'd1, 3'b101, 5'd4, 7'b0010011), 32'h44, 32'h8000_0000, 32'd0);
        step();
        chk("srai_ula_op", 32'(ex_ula_op), 32'd7);
        chk("srai_op_a", ex_op_a, 32'h8000_0000);
        chk("srai_op_b", ex_op_b, 32'd31);

        // SRL x5,x1,x2 with rs2=0x123: shift amount masked to 3
        drive(r_type(7'h00, 5'd2, 5'd1, 3'b101, 5'd5), 32'h48, 32'hF0, 32'h123);
        step();
        chk("srl_ula_op", 32'(ex_ula_op), 32'd6);
        chk("srl_op_b", ex_op_b, 32'd3);

        // LUI x8,0x12345 and AUIPC x9,0x1
        drive({20'h12345, 5'd8, 7'b0110111}, 32'h4C, 32'hAAAA, 32'hBBBB);
        step();
        chk("lui_op_a", ex_op_a, 32'd0);
        chk("lui_op_b", ex_op_b, 32'h1234_5000);
        drive({20'h00001, 5'd9, 7'b0010111}, 32'h100, 32'hAAAA, 32'hBBBB);
        step();
        chk("auipc_op_a", ex_op_a, 32'h100);
        chk("auipc_op_b", ex_op_b, 32'h1000);
        chk("auipc_ula_op", 32'(ex_ula_op), 32'd0);

        // SW x2,8(x1)
        drive({7'h00, 5'd2, 5'd1, 3'b010, 5'd8, 7'b0100011}, 32'h104, 32'h1000, 32'hDEAD);
        step();
        chk("sw_op_a", ex_op_a, 32'h1000);
        chk("sw_op_b", ex_op_b, 32'd8);
        chk("sw_mem_write", 32'(ex_mem_write), 32'd1);
        chk("sw_reg_write", 32'(ex_reg_write), 32'd0);
        chk("sw_store_data", ex_store_data, 32'hDEAD);
        chk("sw_funct3", 32'(ex_funct3), 32'd2);

        // JAL x1
        drive({20'h00000, 5'd1, 7'b1101111}, 32'h200, 32'd0, 32'd0);
        step();
        chk("jal_op_a", ex_op_a, 32'h200);
        chk("jal_op_b", ex_op_b, 32'd4);
        chk("jal_jump", 32'(ex_jump), 32'd1);
        chk("jal_reg_write", 32'(ex_reg_write), 32'd1);

        // LW x6,-4(x1) then ADD x7,x6,x2: one bubble
        drive(i_type(12'hFFC, 5'd1, 3'b010, 5'd6, 7'b0000011), 32'h204, 32'h2000, 32'd0);
        step();
        chk("lw_mem_read", 32'(ex_mem_read), 32'd1);
        chk("lw_rd", 32'(ex_rd), 32'd6);
        chk("lw_op_a", ex_op_a, 32'h2000);
        chk("lw_op_b", ex_op_b, 32'hFFFF_FFFC);
        drive(r_type(7'h00, 5'd2, 5'd6, 3'b000, 5'd7), 32'h208, 32'd11, 32'd22);
        #1 chk("hz_ready_low", 32'(id_ready), 32'd0);
        step();
        chk("hz_bubble_valid", 32'(ex_valid), 32'd0);
        chk("hz_ready_back", 32'(id_ready), 32'd1);
        step();
        chk("hz_add_valid", 32'(ex_valid), 32'd1);
        chk("hz_add_rd", 32'(ex_rd), 32'd7);
        chk("hz_add_op_a", ex_op_a, 32'd11);
        chk("hz_add_op_b", ex_op_b, 32'd22);

        // LW x0,0(x1) then ADD x7,x0,x2: no bubble
        drive(i_type(12'h000, 5'd1, 3'b010, 5'd0, 7'b0000011), 32'h20C, 32'h3000, 32'd0);
        step();
        drive(r_type(7'h00, 5'd2, 5'd0, 3'b000, 5'd7), 32'h210, 32'd0, 32'd9);
        #1 chk("x0_ready", 32'(id_ready), 32'd1);
        step();
        chk("x0_add_valid", 32'(ex_valid), 32'd1);
        chk("x0_add_rd", 32'(ex_rd), 32'd7);

        // BLTU x1,x2
        drive({7'h00, 5'd2, 5'd1, 3'b110, 5'd0, 7'b1100011}, 32'h214, 32'd3, 32'd9);
        step();
        chk("bltu_ula_op", 32'(ex_ula_op), 32'd9);
        chk("bltu_branch", 32'(ex_branch), 32'd1);
        chk("bltu_reg_write", 32'(ex_reg_write), 32'd0);
        chk("bltu_op_b", ex_op_b, 32'd9);
        drive(r_type(7'h00, 5'd2, 5'd1, 3'b000, 5'd3), 32'h218, 32'd1, 32'd1);
        ex_stall = 1'b1;
        ex_flush = 1'b1;
        #1 chk("flush_ready", 32'(id_ready), 32'd1);
        step();
        chk("flush_valid", 32'(ex_valid), 32'd0);
        ex_stall = 1'b0;
        ex_flush = 1'b0;

        // stall for 3 cycles, then async reset mid-stall
        drive(r_type(7'h00, 5'd2, 5'd1, 3'b000, 5'd3), 32'h21C, 32'd5, 32'd7);
        step();
        drive(r_type(7'h20, 5'd2, 5'd1, 3'b000, 5'd10), 32'h220, 32'd100, 32'd1);
        ex_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1 chk("stall_ready", 32'(id_ready), 32'd0);
            step();
            chk("stall_valid", 32'(ex_valid), 32'd1);
            chk("stall_ula_op", 32'(ex_ula_op), 32'd0);
            chk("stall_op_a", ex_op_a, 32'd5);
            chk("stall_op_b", ex_op_b, 32'd7);
            chk("stall_rd", 32'(ex_rd), 32'd3);
        end
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(ex_valid), 32'd0);
        chk("arst_op_a", ex_op_a, 32'd0);
        chk("arst_op_b", ex_op_b, 32'd0);
        chk("arst_rd", 32'(ex_rd), 32'd0);
        chk("arst_reg_write", 32'(ex_reg_write), 32'd0);
        ex_stall = 1'b0;
        id_valid = 1'b0;
        #3 rst_n = 1'b1;
        step();

        // all-ones word: undecodable opcode
        drive(32'hFFFF_FFFF, 32'h300, 32'h55, 32'h66);
        step();
        chk("ill_valid", 32'(ex_valid), 32'd1);
        chk("ill_reg_write", 32'(ex_reg_write), 32'd0);
        chk("ill_mem_read", 32'(ex_mem_read), 32'd0);
        chk("ill_mem_write", 32'(ex_mem_write), 32'd0);
`ifdef ID_EX_ILLEGAL_CHECK_EN
        chk("ill_flag", 32'(ex_illegal), 32'd1);
        chk("ill_ula_op", 32'(ex_ula_op), 32'd15);
`else
        chk("ill_flag", 32'(ex_illegal), 32'd0);
        chk("ill_ula_op", 32'(ex_ula_op), 32'd0);
`endif

        id_valid = 1'b0;
        step();
        chk("idle_valid", 32'(ex_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
